// File: rtl/inv_mix_col_seq.sv
// inv_mix_col_seq: column sequencer for one AES-256 decryption round.
//
// It XORs the incoming state with the round key (AddRoundKey). On an ordinary
// round it then sends the keyed state one 32-bit column per cycle to an
// external combinational InvMixColumn helper, collects the helper results
// into a 128-bit state and offers that state downstream with valid/ready.
// On the final round the keyed state is offered directly.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_state/in_key/in_last are valid
//   in_ready   block can accept input
//   in_state   cipher state; column 0 = [127:96], column 3 = [31:0]
//   in_key     round key for AddRoundKey
//   in_last    final round: skip InvMixColumns
//   hc_col     column sent to the helper (0 when not mixing)
//   hc_mcl     helper result, combinational function of hc_col
//   out_valid  out_state is valid
//   out_ready  downstream accepts
//   out_state  round result
//   busy       high while columns are being mixed
//
// Build option:
//   INV_MC_REG_EN  registers hc_mcl in a 32-bit pipe register before it is
//                  written into the result. Mixing then takes 5 cycles instead
//                  of 4. Final-round latency does not change.

module inv_mix_col_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic [31:0]  hc_col,
  input  logic [31:0]  hc_mcl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [2:0]   col_idx_reg, col_idx_next;
  logic [127:0] s_reg;
  logic [127:0] r_reg;
  logic [127:0] ark;
  logic         accept;
  logic         mix_done;
  logic [1:0]   cap_col;
  logic [6:0]   cap_base;
  logic [31:0]  s_col [4];

  // Column k sits at bits [127-32k -: 32].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign s_col[gi] = s_reg[127 - 32*gi -: 32];
    end
  endgenerate

  assign ark    = in_state ^ in_key;
  assign accept = in_valid & in_ready;

`ifdef INV_MC_REG_EN
  logic [31:0] pipe_reg;
  // col_idx runs 0..4. Column col_idx-1 is written from the pipe register,
  // so the last write into the result happens when col_idx is 4.
  assign mix_done = (col_idx_reg == 3'd4);
  assign cap_col  = 2'(col_idx_reg[1:0] - 2'd1);
`else
  assign mix_done = (col_idx_reg == 3'd3);
  assign cap_col  = col_idx_reg[1:0];
`endif

  // Bit offset of column cap_col. (3 - k) equals ~k for a 2-bit k.
  assign cap_base  = {~cap_col, 5'd0};
  assign out_state = r_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      col_idx_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      col_idx_reg <= col_idx_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    hc_col       = 32'h0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next   = in_last ? OUT : MIX;
          col_idx_next = 3'd0;
        end
      end
      MIX: begin
        busy = 1'b1;
        // With the pipe register, the fifth cycle only drains it. The helper
        // input is zero in that cycle.
        if (col_idx_reg < 3'd4)
          hc_col = s_col[col_idx_reg[1:0]];
        if (mix_done) begin
          col_idx_next = 3'd0;
          state_next   = OUT;
        end else begin
          col_idx_next = col_idx_reg + 3'd1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        // Accepting new input in the same cycle as the output transfer
        // avoids an idle cycle between blocks.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_next   = in_last ? OUT : MIX;
            col_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        col_idx_next = 3'd0;
      end
    endcase
  end

  // Datapath registers
`ifdef INV_MC_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= 128'h0;
      r_reg    <= 128'h0;
      pipe_reg <= 32'h0;
    end else if (accept) begin
      s_reg <= ark;
      if (in_last)
        r_reg <= ark;
    end else if (state_reg == MIX) begin
      pipe_reg <= hc_mcl;
      if (col_idx_reg != 3'd0)
        r_reg[cap_base +: 32] <= pipe_reg;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= 128'h0;
      r_reg <= 128'h0;
    end else if (accept) begin
      s_reg <= ark;
      if (in_last)
        r_reg <= ark;
    end else if (state_reg == MIX) begin
      r_reg[cap_base +: 32] <= hc_mcl;
    end
  end
`endif

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// tb_inv_mix_col_seq: directed testbench for inv_mix_col_seq.
// The InvMixColumn helper is modelled combinationally in the bench.
// Each scenario task drives its stimulus and checks the results inline.

module tb_inv_mix_col_seq;

`ifdef INV_MC_REG_EN
  localparam int MIX_LAT = 5;
`else
  localparam int MIX_LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic [31:0]  hc_col;
  logic [31:0]  hc_mcl;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  // Values recorded by wait_result
  int          res_cyc;
  int          res_busy;
  logic [31:0] col_seen [8];

  always #5 clk = ~clk;

  inv_mix_col_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .hc_col    (hc_col),
    .hc_mcl    (hc_mcl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mc(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {gmul(a0,4'he) ^ gmul(a1,4'hb) ^ gmul(a2,4'hd) ^ gmul(a3,4'h9),
            gmul(a0,4'h9) ^ gmul(a1,4'he) ^ gmul(a2,4'hb) ^ gmul(a3,4'hd),
            gmul(a0,4'hd) ^ gmul(a1,4'h9) ^ gmul(a2,4'he) ^ gmul(a3,4'hb),
            gmul(a0,4'hb) ^ gmul(a1,4'hd) ^ gmul(a2,4'h9) ^ gmul(a3,4'he)};
  endfunction

  assign hc_mcl = inv_mc(hc_col);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a block and hold it until the rising edge that accepts it.
  // On return the accept edge has passed by 1 time unit.
  task automatic send(input logic [127:0] st, input logic [127:0] key, input logic last);
    int t;
    in_valid = 1'b1;
    in_state = st;
    in_key   = key;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      step;
      t++;
    end
    n_vec++;
    if (t >= 50) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
    end
    step;
    in_valid = 1'b0;
    in_state = '0;
    in_key   = '0;
    $display("txn accept state=%h key=%h last=%b", st, key, last);
  endtask

  // Count cycles from the accept edge until out_valid is high. Also record
  // busy cycles and the hc_col value seen in each cycle.
  task automatic wait_result;
    res_cyc  = 0;
    res_busy = 0;
    for (int i = 0; i < 8; i++) col_seen[i] = 32'hxxxxxxxx;
    while (!out_valid && res_cyc < 20) begin
      if (busy) res_busy++;
      if (res_cyc < 8) col_seen[res_cyc] = hc_col;
      step;
      res_cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_vec++;
    if (hc_col !== 32'h0) begin n_bad++; $display("FAIL reset_hc_col: got %h required 0", hc_col); end
    n_vec++;
    if (out_state !== 128'h0) begin n_bad++; $display("FAIL reset_out_state: got %h required 0", out_state); end
    rst_n = 1'b1;
    step;
    $display("txn reset released");
  endtask

  task automatic test_mix_known;
    logic [127:0] exp;
    exp = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    out_ready = 1'b1;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0);
    wait_result;
    n_vec++;
    if (res_cyc !== MIX_LAT) begin n_bad++; $display("FAIL mix_latency: got %0d required %0d", res_cyc, MIX_LAT); end
    n_vec++;
    if (res_busy !== MIX_LAT) begin n_bad++; $display("FAIL mix_busy_cycles: got %0d required %0d", res_busy, MIX_LAT); end
    n_vec++;
    if (out_state !== exp) begin n_bad++; $display("FAIL mix_out_state: got %h required %h", out_state, exp); end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mix_busy_in_out: got %b required 0", busy); end
    step;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mix_to_idle: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    $display("txn mix result %h", exp);
  endtask

  task automatic test_last_round;
    logic [127:0] exp;
    exp = 128'hffeeddcc_44556677_77665544_ccddeeff;
    out_ready = 1'b1;
    send(128'h00112233_44556677_8899aabb_ccddeeff, 128'hffffffff_00000000_ffffffff_00000000, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL last_latency: out_valid got %b required 1", out_valid); end
    n_vec++;
    if (out_state !== exp) begin n_bad++; $display("FAIL last_out_state: got %h required %h", out_state, exp); end
    n_vec++;
    if (hc_col !== 32'h0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL last_hc_col: got hc_col=%h busy=%b required 0/0", hc_col, busy);
    end
    step;
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL last_to_idle: got %b required 0", out_valid); end
    $display("txn last result %h", exp);
  endtask

  task automatic test_column_order;
    logic [127:0] exp;
    logic [31:0]  want;
    exp = 128'h090d0b0e_121a161c_1b171d12_24342c38;
    out_ready = 1'b1;
    send(128'h00000001_00000002_00000003_00000004, 128'h0, 1'b0);
    wait_result;
    for (int k = 0; k < 4; k++) begin
      want = 32'(k + 1);
      n_vec++;
      if (col_seen[k] !== want) begin
        n_bad++;
        $display("FAIL col_order_%0d: got %h required %h", k, col_seen[k], want);
      end
    end
`ifdef INV_MC_REG_EN
    n_vec++;
    if (col_seen[4] !== 32'h0) begin n_bad++; $display("FAIL col_order_drain: got %h required 0", col_seen[4]); end
`endif
    n_vec++;
    if (out_state !== exp) begin n_bad++; $display("FAIL col_order_result: got %h required %h", out_state, exp); end
    step;
    $display("txn column order result %h", exp);
  endtask

  task automatic test_back_to_back;
    logic [127:0] exp_a, exp_b, st, key;
    exp_a = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    exp_b = 128'hffeeddcc_44556677_77665544_ccddeeff;
    out_ready = 1'b0;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0);
    wait_result;
    n_vec++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid_timeout: got %b required 1", out_valid); end
    // Offer the next block while stalled; it must not be taken.
    in_valid = 1'b1;
    in_state = 128'h00112233_44556677_8899aabb_ccddeeff;
    in_key   = 128'hffffffff_00000000_ffffffff_00000000;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_state !== exp_a || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got state=%h in_ready=%b out_valid=%b required %h/0/1",
                 i, out_state, in_ready, out_valid, exp_a);
      end
      step;
    end
    // Release: transfer of A and accept of B on the same edge
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b required 1", in_ready); end
    step;
    n_vec++;
    if (out_valid !== 1'b1 || out_state !== exp_b) begin
      n_bad++;
      $display("FAIL b2b_no_bubble: got valid=%b state=%h required 1/%h", out_valid, out_state, exp_b);
    end
    $display("txn back-to-back result %h", exp_b);
    // Final-round blocks streaming one per cycle
    for (int i = 0; i < 3; i++) begin
      st  = {4{32'(32'h10203040 + i)}};
      key = {32'h0, 32'hffffffff, 32'(i), 32'h5a5a5a5a};
      in_state = st;
      in_key   = key;
      step;
      n_vec++;
      if (out_valid !== 1'b1 || out_state !== (st ^ key)) begin
        n_bad++;
        $display("FAIL stream_%0d: got valid=%b state=%h required 1/%h", i, out_valid, out_state, st ^ key);
      end
      $display("txn stream %0d result %h", i, st ^ key);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_to_idle: got valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_mix;
    out_ready = 1'b1;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0);
    step;
    step;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || hc_col !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_mix: got valid=%b in_ready=%b busy=%b hc_col=%h required 0/1/0/0",
               out_valid, in_ready, busy, hc_col);
    end
    n_vec++;
    if (out_state !== 128'h0) begin n_bad++; $display("FAIL rst_mid_mix_state: got %h required 0", out_state); end
    #3;
    rst_n = 1'b1;
    step;
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_result: got %b required 0", out_valid); end
    $display("txn reset during mix");
    test_mix_known;
  endtask

  initial begin
    test_reset;
    test_mix_known;
    test_last_round;
    test_column_order;
    test_back_to_back;
    test_reset_mid_mix;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inv_mix_col_seq.md
Name: inv_mix_col_seq

Overview:
- Column sequencer for the AES-256 decryption round datapath.
- Accepts a 128-bit state and a 128-bit round key, performs AddRoundKey, then streams the result one 32-bit column per cycle into the external combinational inverse-MixColumn helper.
- Captures the helper's column results, reassembles the 128-bit state and presents it downstream with a valid/ready handshake.
- On the final round, InvMixColumns is skipped and only AddRoundKey is applied.

Parameters:
- none (widths fixed by AES: state 128, column 32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state/in_key/in_last valid
- in_ready  output  1  block can accept input
- in_state  input  128  cipher state; column 0 = [127:96], column 3 = [31:0]
- in_key  input  128  round key for AddRoundKey
- in_last  input  1  final round: skip InvMixColumns
- hc_col  output  32  column to helper input (rc)
- hc_mcl  input  32  helper result (mcl), combinational function of hc_col
- out_valid  output  1  out_state valid
- out_ready  input  1  downstream accepts
- out_state  output  128  round result
- busy  output  1  high in MIX state

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, col_idx=0
  - in_ready=1, out_valid=0, busy=0
  - out_state=0, hc_col=0
  - internal s_reg=0, r_reg=0
- States: IDLE, MIX, OUT.
- Input accept: in_valid & in_ready at a rising edge.
  - s_reg <= in_state ^ in_key.
  - in_last=1: r_reg <= in_state ^ in_key, next OUT.
  - in_last=0: col_idx <= 0, next MIX.
- MIX:
  - hc_col = s_reg column col_idx, combinational from s_reg/col_idx.
  - Each edge: r_reg column col_idx <= hc_mcl; col_idx increments.
  - After column 3 is captured: col_idx wraps to 0, next OUT.
  - busy=1 only here. in_ready=0.
- hc_col = 32'h0 in IDLE and OUT.
- OUT:
  - out_valid=1, out_state=r_reg.
  - On out_valid & out_ready, out_state/r_reg are held until the transfer completes.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- Simultaneous output transfer and input accept in OUT: the new input is taken the same edge; next state follows the in_last rule. No bubble.
- Transfer in OUT with no new input: next IDLE.
- Latency, accept edge to out_valid high:
  - 4 cycles for mix rounds.
  - 1 cycle for last rounds.
- Throughput: one block per 5 cycles (mix) or per 1 cycle (last), with out_ready held high.
- Holding rules:
  - in_valid is ignored while in_ready=0.
  - in_* may change freely after acceptance; s_reg holds the copy.
- out_ready low in OUT: hold state indefinitely, outputs stable.
- Reset asserted mid-MIX or mid-OUT: all state returns to reset values immediately. Partial result is discarded, no out_valid.
- All XORs are bitwise. No arithmetic carries.

Optional Feature:
- Macro INV_MC_REG_EN.
- Defined:
  - hc_mcl is registered into a 32-bit pipe register before capture into r_reg.
  - MIX lasts 5 cycles. Column k is captured at the (k+2)th edge after accept.
  - hc_col continues to step columns 0..3 during the first 4 MIX cycles, then is 0.
  - Mix-round latency becomes 5 cycles. Last-round latency is unchanged at 1.
- Undefined: behaviour as above, with direct capture and a 4-cycle latency.

Test Plan:
- Mix round, known columns: in_key=0, in_last=0, in_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, with the bench helper model performing InvMixColumns.
  - Required: out_state=128'hdb135345_f20a225c_01010101_c6c6c6c6.
  - out_valid exactly 4 cycles after accept (5 with INV_MC_REG_EN).
  - busy high for 4 (5) cycles.
- AddRoundKey, last round: in_state=128'h00112233_44556677_8899aabb_ccddeeff, in_key=128'hffffffff_00000000_ffffffff_00000000, in_last=1.
  - Required: out_state=128'hffeeddcc_44556677_77665544_ccddeeff one cycle after accept.
  - hc_col stays 0.
- Column order: in_state=128'h00000001_00000002_00000003_00000004, key 0, mix.
  - Required: hc_col sequence 00000001, 00000002, 00000003, 00000004 on consecutive cycles.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in OUT → out_state stable, in_ready=0.
  - Then assert out_ready with in_valid high → second block accepted on the same edge as the output transfer, no idle cycle.
- Reset mid-MIX: assert rst_n=0 asynchronously after the 2nd column is captured.
  - Required: out_valid=0, in_ready=1, busy=0, hc_col=0 immediately.
  - Next block processes correctly with no residue.
